counter_access_arbiter: RTL and testbench
=========================================

Name: counter_access_arbiter

Overview:
- Shares the two-counter core's register-access port (load and read of counter1/counter2) between NUM_REQ independent requesters, for example the bus slave and a DMA/debug agent.
- Grants one request at a time, round-robin by default.
- Sequences the core's write-enable and read-enable strobes.
- Returns an atomic read value or write acknowledge to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- DATA_W, 32, width of the counter data path. Must match the core.
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  NUM_REQ  per-requester request. Held high until the matching req_ack is sampled.
- req_write  in  NUM_REQ  per-requester op: 1 = load counter, 0 = read counter.
- req_sel  in  NUM_REQ  per-requester target: 0 = counter1, 1 = counter2.
- req_wdata  in  NUM_REQ*DATA_W  per-requester load value. Requester i uses slice [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-hot, single-cycle completion strobe.
- rdata  out  DATA_W  read result; valid in the req_ack cycle of a read.
- grant_id  out  ID_W  index of the current/last granted requester.
- busy  out  1  high while not in IDLE.
- counter1  in  DATA_W  counter1 value from the core.
- counter2  in  DATA_W  counter2 value from the core.
- counter1In  out  DATA_W  load value to the core.
- counter2In  out  DATA_W  load value to the core.
- counter1We  out  1  core counter1 load strobe.
- counter2We  out  1  core counter2 load strobe.
- counter1Re  out  1  core counter1 read strobe.
- counter2Re  out  1  core counter2 read strobe.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - State = IDLE.
  - All We/Re = 0; counter1In/counter2In = 0.
  - req_ack = 0; rdata = 0; grant_id = 0; busy = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority first.
- FSM has three states:
  - IDLE -> EXEC when any req_valid=1.
  - EXEC -> ACK unconditionally.
  - ACK -> IDLE unconditionally.
- Throughput is one operation per 3 cycles; no back-to-back EXEC.
- Arbitration (IDLE only):
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping.
  - The first set bit wins.
  - On the IDLE->EXEC edge, latch into internal registers: winner index, op, sel and wdata. Set last_grant and grant_id to the winner.
- EXEC cycle, registered outputs asserted for exactly this cycle:
  - Write op: counterXWe=1 and counterXIn=latched wdata, where X = sel+1. The core loads on the EXEC->ACK edge.
  - Read op: counterXRe=1. rdata captures counterX as sampled on the EXEC->ACK edge.
- ACK cycle:
  - req_ack[winner]=1 for exactly one cycle.
  - rdata holds the read value. It is unchanged by writes and holds until the next read completes.
- The requester drops req_valid on the edge where it samples req_ack=1. It is therefore not re-granted in the following IDLE.
- A request whose req_valid drops mid-operation still completes and acks; inputs are latched.
- Non-selected counterXIn hold their previous value.
- Never more than one of the four We/Re strobes is high in any cycle.
- Requesters not granted wait with no timeout. Round-robin bounds the wait to NUM_REQ operations.
- req_wdata/req_sel/req_write changes after the grant are ignored.
- If reset is asserted mid-operation, the FSM returns to IDLE immediately with no ack, and all strobes drop asynchronously.
- busy=1 in EXEC and ACK.

Optional Feature:
- Macro: COUNTER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest index always wins. last_grant is still updated (it drives grant_id) but is ignored by the search.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single write: req 0 writes 0x0000_1234 to counter2 (sel=1).
  - counter2We=1 for one cycle, 1 cycle after the request; counter2In=0x1234.
  - req_ack[0] the next cycle.
  - counter2 reads 0x1234, then increments.
- Single read: core counter1 runs free from reset; req 1 reads counter1 (sel=0).
  - counter1Re=1 in EXEC.
  - rdata in the ACK cycle equals the counter1 value present during EXEC, e.g. 0x0000_0005 if EXEC is cycle 5 after reset release.
- Contention: req 0 and req 1 both hold valid continuously and issue 4 ops each.
  - Grant order is 0,1,0,1,...
  - With COUNTER_ARB_FIXED_PRIO_EN, all of req 0 completes before any of req 1.
- Drop mid-op: req 0 deasserts req_valid during EXEC.
  - Operation still completes; req_ack[0] is high in ACK.
  - No second grant follows.
- Reset mid-op: assert reset (0) during EXEC of a write.
  - counter2We goes 0 immediately; no req_ack.
  - After release: state IDLE, busy=0, and a pending req 1 is granted before req 0 only if req 0 is not valid.
- Strobe exclusivity: random requests over 1000 cycles.
  - At most one We/Re high per cycle.
  - Every accepted request gets exactly one req_ack.

Source files
------------

// File: rtl/counter_access_arbiter.sv
// Arbitrates NUM_REQ requesters onto the two-counter core's load/read port, one op per 3 cycles.
// Define COUNTER_ARB_FIXED_PRIO_EN for fixed (lowest index wins) priority; default is round-robin.
module counter_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_sel,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    input  logic [DATA_W-1:0]         counter1,
    input  logic [DATA_W-1:0]         counter2,
    output logic [DATA_W-1:0]         counter1In,
    output logic [DATA_W-1:0]         counter2In,
    output logic                      counter1We,
    output logic                      counter2We,
    output logic                      counter1Re,
    output logic                      counter2Re
);

    // state | meaning
    // IDLE  | waiting for any req_valid; arbitration happens here
    // EXEC  | one We/Re strobe to the core for the latched op
    // ACK   | req_ack to the winner; rdata valid for reads
    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick;
    logic            found;
    logic            op_write;
    logic            op_sel;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef COUNTER_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(last_grant) + 1 + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            op_write   <= 1'b0;
            op_sel     <= 1'b0;
            req_ack    <= '0;
            rdata      <= '0;
            counter1In <= '0;
            counter2In <= '0;
            counter1We <= 1'b0;
            counter2We <= 1'b0;
            counter1Re <= 1'b0;
            counter2Re <= 1'b0;
        end else begin
            counter1We <= 1'b0;
            counter2We <= 1'b0;
            counter1Re <= 1'b0;
            counter2Re <= 1'b0;
            req_ack    <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= EXEC;
                        last_grant <= pick;
                        grant_id   <= pick;
                        op_write   <= req_write[pick];
                        op_sel     <= req_sel[pick];
                        // the load value is latched straight into the selected counterXIn
                        if (req_write[pick]) begin
                            if (req_sel[pick]) begin
                                counter2We <= 1'b1;
                                counter2In <= req_wdata[int'(pick)*DATA_W +: DATA_W];
                            end else begin
                                counter1We <= 1'b1;
                                counter1In <= req_wdata[int'(pick)*DATA_W +: DATA_W];
                            end
                        end else begin
                            if (req_sel[pick]) counter2Re <= 1'b1;
                            else               counter1Re <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    state             <= ACK;
                    req_ack[grant_id] <= 1'b1;
                    if (!op_write) rdata <= op_sel ? counter2 : counter1;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Bench for counter_access_arbiter: free-running two-counter core model, directed vectors
// with a scoreboard queue checked by an independent ack monitor, then a random soak.
module tb_counter_access_arbiter;
    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        req_valid, req_write, req_sel;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]         rdata;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic [DATA_W-1:0]         counter1, counter2, counter1In, counter2In;
    logic                      counter1We, counter2We, counter1Re, counter2Re;

    logic              tv [NUM_REQ];
    logic              tw [NUM_REQ];
    logic              ts [NUM_REQ];
    logic [DATA_W-1:0] td [NUM_REQ];

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_on = 1'b1;
    bit   rand_done = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   issued [NUM_REQ];
    int   acked  [NUM_REQ];

    counter_access_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_sel(req_sel), .req_wdata(req_wdata),
        .req_ack(req_ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
        .counter1(counter1), .counter2(counter2),
        .counter1In(counter1In), .counter2In(counter2In),
        .counter1We(counter1We), .counter2We(counter2We),
        .counter1Re(counter1Re), .counter2Re(counter2Re)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_write = '0;
        req_sel   = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = tv[i];
            req_write[i] = tw[i];
            req_sel[i]   = ts[i];
            req_wdata[i*DATA_W +: DATA_W] = td[i];
        end
    end

    // core model: counters free-run from reset and load on their We strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter1 <= '0;
            counter2 <= '0;
        end else begin
            counter1 <= counter1We ? counter1In : counter1 + 1;
            counter2 <= counter2We ? counter2In : counter2 + 1;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("strobe_exclusive",
                  32'($countones({counter1We, counter2We, counter1Re, counter2Re}) > 1), 32'd0);
            if (req_ack != '0) begin
                if (sb_on) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_ack", 32'(req_ack), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("ack_onehot", 32'(req_ack), 32'd1 << e.id);
                        check("grant_id", 32'(grant_id), 32'(e.id));
                        check("rdata", rdata, e.data);
                    end
                end else begin
                    check("ack_onehot_rand", 32'($onehot(req_ack)), 32'd1);
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (req_ack[i]) begin
                            check("ack_while_valid", 32'(tv[i]), 32'd1);
                            acked[i]++;
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_req(int i, bit w, bit s, logic [31:0] d);
        tw[i] = w;
        ts[i] = s;
        td[i] = d;
        tv[i] = 1'b1;
        issued[i]++;
    endtask

    task automatic wait_ack(int i, bit keep);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ack[i]) got = 1'b1;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        if (!keep || !got) begin
            #1;
            tv[i] = 1'b0;
        end
    endtask

    task automatic rand_agent(int i);
        while (!rand_done) begin
            repeat ($urandom_range(6, 2)) @(negedge clk);
            if (!rand_done) begin
                set_req(i, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom);
                wait_ack(i, 1'b0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            tv[i] = 1'b0; tw[i] = 1'b0; ts[i] = 1'b0; td[i] = '0;
            issued[i] = 0; acked[i] = 0;
        end

        // reset state
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_strobes", 32'({counter1We, counter2We, counter1Re, counter2Re}), 32'd0);
        check("rst_in", counter1In | counter2In, 32'd0);

        // single write of 0x1234 to counter2, read back, then a write that must not touch rdata
        do_reset();
        sb_q.push_back('{id: 0, data: 32'h0});
        set_req(0, 1'b1, 1'b1, 32'h1234);
        @(negedge clk);
        check("wr_c2we", 32'(counter2We), 32'd1);
        check("wr_c2in", counter2In, 32'h1234);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_other_strobes", 32'({counter1We, counter1Re, counter2Re}), 32'd0);
        wait_ack(0, 1'b0);
        check("wr_core_load", counter2, 32'h1234);
        check("wr_busy_ack", 32'(busy), 32'd1);
        @(negedge clk);
        check("wr_core_inc", counter2, 32'h1235);
        check("wr_we_dropped", 32'(counter2We), 32'd0);
        check("wr_idle_busy", 32'(busy), 32'd0);
        sb_q.push_back('{id: 0, data: 32'h1236});
        set_req(0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        check("rd2_c2re", 32'(counter2Re), 32'd1);
        wait_ack(0, 1'b0);
        sb_q.push_back('{id: 1, data: 32'h1236});
        set_req(1, 1'b1, 1'b0, 32'h55);
        wait_ack(1, 1'b0);
        check("wr1_core_load", counter1, 32'h55);
        check("wr1_c2in_held", counter2In, 32'h1234);

        // read of free-running counter1 with EXEC in cycle 5 after reset release
        do_reset();
        repeat (4) @(negedge clk);
        sb_q.push_back('{id: 1, data: 32'h5});
        set_req(1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rd_c1re", 32'(counter1Re), 32'd1);
        wait_ack(1, 1'b0);

        // requester drops valid during EXEC: still acked once, no regrant
        do_reset();
        sb_q.push_back('{id: 0, data: 32'h1});
        set_req(0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("drop_busy_exec", 32'(busy), 32'd1);
        tv[0] = 1'b0;
        wait_ack(0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("drop_no_regrant", 32'(busy), 32'd0);
        end

        // reset during EXEC of a write: strobe drops at once, no ack; req 1 then wins alone
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'hABCD);
        @(negedge clk);
        check("rmid_c2we_exec", 32'(counter2We), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rmid_c2we_async", 32'(counter2We), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_ack", 32'(req_ack), 32'd0);
        tv[0] = 1'b0;
        set_req(1, 1'b0, 1'b0, 32'h0);
        sb_q.push_back('{id: 1, data: 32'h1});
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_ack(1, 1'b0);

        // contention: both hold valid continuously for 4 writes each
        do_reset();
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 8; k++) sb_q.push_back('{id: (k < 4) ? 0 : 1, data: 32'h0});
`else
        for (int k = 0; k < 8; k++) sb_q.push_back('{id: k % 2, data: 32'h0});
`endif
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    set_req(0, 1'b1, 1'(k % 2), 32'h100 + 32'(k));
                    wait_ack(0, k < 3);
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    set_req(1, 1'b1, 1'(k % 2), 32'h200 + 32'(k));
                    wait_ack(1, k < 3);
                end
            end
        join
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // random soak: exclusivity every cycle, exactly one ack per accepted request
        do_reset();
        sb_on = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            issued[i] = 0;
            acked[i]  = 0;
        end
        fork
            begin
                repeat (1000) @(negedge clk);
                rand_done = 1'b1;
            end
            rand_agent(0);
            rand_agent(1);
        join
        repeat (4) @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) check("acks_per_request", 32'(acked[i]), 32'(issued[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
